// File: rtl/pmc14495.sv
// Registered hex-to-seven-segment decoder (MC14495 style), active-low a..g and p, with LE blanking.
// Latency 1 cycle, new nibble accepted every cycle, no backpressure; rst outranks LE, LE outranks data.
module pmc14495 (
  input  logic clk,
  input  logic rst,
  input  logic D3,
  input  logic D2,
  input  logic D1,
  input  logic D0,
  input  logic point,
  input  logic LE,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic p
);

  logic [3:0] nib;
  logic [6:0] lit;  // {a,b,c,d,e,f,g}, 1 = segment lit

  assign nib = {D3, D2, D1, D0};

  always_comb begin
    lit = 7'b0000000;
    case (nib)
      4'h0: lit = 7'b1111110;
      4'h1: lit = 7'b0110000;
      4'h2: lit = 7'b1101101;
      4'h3: lit = 7'b1111001;
      4'h4: lit = 7'b0110011;
      4'h5: lit = 7'b1011011;
      4'h6: lit = 7'b1011111;
      4'h7: lit = 7'b1110000;
      4'h8: lit = 7'b1111111;
      4'h9: lit = 7'b1111011;
      4'hA: lit = 7'b1110111;
      4'hB: lit = 7'b0011111;
      4'hC: lit = 7'b1001110;
      4'hD: lit = 7'b0111101;
      4'hE: lit = 7'b1001111;
      4'hF: lit = 7'b1000111;
      default: lit = 7'b0000000;
    endcase
  end

  // Outputs are driven straight from these flops; inverting here keeps the pins glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      {a, b, c, d, e, f, g, p} <= 8'hFF;
    end else if (LE) begin
      {a, b, c, d, e, f, g, p} <= 8'hFF;
    end else begin
      {a, b, c, d, e, f, g} <= ~lit;
      p                     <= ~point;
    end
  end

endmodule

// File: tb/tb_pmc14495.sv
// Self-checking bench for pmc14495: directed scenarios plus randomized traffic against a
// reference model built from per-digit lists of lit segment letters.
module tb_pmc14495;

  logic clk = 1'b0;
  logic rst, D3, D2, D1, D0, point, LE;
  logic a, b, c, d, e, f, g, p;

  int checks   = 0;
  int failures = 0;

  string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  pmc14495 dut (
    .clk(clk), .rst(rst), .D3(D3), .D2(D2), .D1(D1), .D0(D0), .point(point), .LE(LE),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .p(p)
  );

  always #5 clk = ~clk;

  // Expected {a..g,p}: start all dark, clear the bit of each listed segment letter.
  function automatic logic [7:0] model(input int n, input bit pt, input bit le, input bit r);
    logic [6:0] m;
    int idx;
    if (r || le) return 8'hFF;
    m = 7'h7F;
    for (int k = 0; k < segs[n].len(); k++) begin
      idx = int'(segs[n].getc(k)) - int'("a");
      m[6 - idx] = 1'b0;
    end
    return {m, ~pt};
  endfunction

  function automatic logic [7:0] obs();
    return {a, b, c, d, e, f, g, p};
  endfunction

  // Apply inputs shortly after an edge, then advance to 1 time unit past the next edge.
  task automatic drive(input int n, input bit pt, input bit le, input bit r);
    logic [3:0] nv;
    nv = n[3:0];
    {D3, D2, D1, D0} = nv;
    point = pt;
    LE    = le;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(8, 1, 0, 1);
      checks++;
      if (obs() !== 8'hFF) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got %b want %b", i, obs(), 8'hFF);
      end
    end
    drive(8, 1, 0, 0);
    checks++;
    if (obs() !== 8'h00) begin
      failures++;
      $display("FAIL reset_release: got %b want %b", obs(), 8'h00);
    end
  endtask

  task automatic test_hex_sweep();
    logic [7:0] exp;
    for (int n = 0; n < 16; n++) begin
      drive(n, 0, 0, 0);
      exp = model(n, 0, 0, 0);
      checks++;
      if (obs() !== exp) begin
        failures++;
        $display("FAIL hex_sweep N=%0d: got %b want %b", n, obs(), exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seen [31];
    logic [7:0] exp;
    bit pt;
    for (int i = 0; i <= 30; i++) begin
      pt = (i % 2) == 1;
      drive(i % 16, pt, 0, 0);
      seen[i] = obs();
      exp = model(i % 16, pt, 0, 0);
      checks++;
      if (seen[i] !== exp) begin
        failures++;
        $display("FAIL wrap_decode i=%0d: got %b want %b", i, seen[i], exp);
      end
    end
    for (int i = 16; i <= 30; i++) begin
      checks++;
      if (seen[i] !== seen[i - 16]) begin
        failures++;
        $display("FAIL wrap_repeat i=%0d: got %b want %b", i, seen[i], seen[i - 16]);
      end
    end
  endtask

  task automatic test_blanking();
    drive(8, 1, 1, 0);
    checks++;
    if (obs() !== 8'hFF) begin
      failures++;
      $display("FAIL blank_on: got %b want %b", obs(), 8'hFF);
    end
    drive(8, 1, 0, 0);
    checks++;
    if (obs() !== 8'h00) begin
      failures++;
      $display("FAIL blank_off: got %b want %b", obs(), 8'h00);
    end
  endtask

  task automatic test_reset_priority();
    drive(8, 1, 0, 0);
    drive(8, 1, 0, 1);
    checks++;
    if (obs() !== 8'hFF) begin
      failures++;
      $display("FAIL reset_priority: got %b want %b", obs(), 8'hFF);
    end
  endtask

  task automatic test_latency();
    logic [7:0] e0, e7;
    e0 = model(0, 0, 0, 0);
    e7 = model(7, 0, 0, 0);
    drive(0, 0, 0, 0);
    #2;
    {D3, D2, D1, D0} = 4'd7;
    #1;
    checks++;
    if (obs() !== e0) begin
      failures++;
      $display("FAIL latency_hold: got %b want %b", obs(), e0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== e7) begin
      failures++;
      $display("FAIL latency_update: got %b want %b", obs(), e7);
    end
  endtask

  task automatic test_random();
    int n;
    bit pt, le, r;
    logic [7:0] exp;
    for (int i = 0; i < 300; i++) begin
      n  = int'($urandom_range(0, 15));
      pt = $urandom_range(0, 1) == 1;
      le = $urandom_range(0, 3) == 0;
      r  = $urandom_range(0, 15) == 0;
      drive(n, pt, le, r);
      exp = model(n, pt, le, r);
      checks++;
      if (obs() !== exp) begin
        failures++;
        $display("FAIL random i=%0d N=%0d pt=%0b LE=%0b rst=%0b: got %b want %b",
                 i, n, pt, le, r, obs(), exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; LE = 1'b0; point = 1'b0; {D3, D2, D1, D0} = 4'd0;
    #1;
    test_reset();
    test_hex_sweep();
    test_wrap();
    test_blanking();
    test_reset_priority();
    test_latency();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
